// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank read path: FSM encodings,
// default geometry and a width helper for elaboration-time checks.
package reg_bank_pkg;

  // Reader FSM: either waiting for a request or holding one beat for the consumer
  typedef enum logic {
    RB_IDLE  = 1'b0,
    RB_VALID = 1'b1
  } rb_state_t;

  // Default register width and register count of the bank
  localparam int REG_W = 8;
  localparam int NREGS = 4;

  // Number of bits needed to index 'value' distinct items (minimum 0)
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/reg_slice_mux.sv
// Combinational selector that picks one n-bit register out of the
// flattened bank bus and reports whether the index names a real register.
module reg_slice_mux #(
  parameter int n     = 8,
  parameter int NREGS = 4,
  parameter int SEL_W = 2
) (
  input  logic [NREGS*n-1:0] reg_bus,
  input  logic [SEL_W-1:0]   idx,
  output logic [n-1:0]       slice,
  output logic               in_range
);
  import reg_bank_pkg::*;

  logic [SEL_W:0] w_idxWide;

  // Widen by one bit so the range compare is never trivially constant
  assign w_idxWide = {1'b0, idx};
  assign in_range  = (w_idxWide < (SEL_W+1)'(NREGS));

  // Out-of-range indices fall through to an all-zero slice
  always_comb begin
    slice = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (idx == SEL_W'(k)) begin
        slice = reg_bus[k*n +: n];
      end
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Read port for the loadable register bank: snapshots one register or a
// run of registers and presents each value as a held beat on a valid/ack
// handshake, so the consumer never sees a value change mid-transfer.
module reg_bank_reader #(
  parameter int n     = reg_bank_pkg::REG_W,
  parameter int NREGS = reg_bank_pkg::NREGS,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [NREGS*n-1:0] reg_bus,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  input  logic               rd_burst,
  input  logic               rd_ack,
  output logic [n-1:0]       rd_data,
  output logic [SEL_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               rd_err,
  output logic               busy
);
  import reg_bank_pkg::*;

  localparam int MIN_SEL_W = clog2(NREGS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREGS - 1);

  if (SEL_W < MIN_SEL_W || NREGS < 2) begin : g_badParams
    $error("reg_bank_reader: SEL_W too narrow for NREGS, or NREGS < 2");
  end

  rb_state_t        r_state;
  rb_state_t        w_nextState;
  logic [n-1:0]     r_data;
  logic [SEL_W-1:0] r_idx;
  logic             r_last;
  logic             r_err;
  logic             r_burst;

  logic [n-1:0]     w_nextData;
  logic [SEL_W-1:0] w_nextIdx;
  logic             w_nextLast;
  logic             w_nextErr;
  logic             w_nextBurst;

  logic [SEL_W-1:0] w_muxIdx;
  logic [n-1:0]     w_slice;
  logic             w_inRange;

  // One shared selector: start index when idle, next burst index otherwise
  assign w_muxIdx = (r_state == RB_IDLE) ? rd_sel : (r_idx + SEL_W'(1));

  reg_slice_mux #(
    .n     (n),
    .NREGS (NREGS),
    .SEL_W (SEL_W)
  ) u_sliceMux (
    .reg_bus  (reg_bus),
    .idx      (w_muxIdx),
    .slice    (w_slice),
    .in_range (w_inRange)
  );

  // Next-state and next-beat selection; everything holds unless a request or ack moves it
  always_comb begin
    w_nextState = r_state;
    w_nextData  = r_data;
    w_nextIdx   = r_idx;
    w_nextLast  = r_last;
    w_nextErr   = r_err;
    w_nextBurst = r_burst;
    case (r_state)
      RB_IDLE: begin
        if (rd_req) begin
          w_nextState = RB_VALID;
          w_nextData  = w_inRange ? w_slice : '0;
          w_nextIdx   = rd_sel;
          w_nextBurst = rd_burst;
          w_nextErr   = !w_inRange;
          w_nextLast  = !rd_burst || !w_inRange || (rd_sel == LAST_IDX);
        end
      end
      RB_VALID: begin
        if (rd_ack) begin
          if (r_last) begin
            w_nextState = RB_IDLE;
          end else begin
            w_nextData = w_slice;
            w_nextIdx  = w_muxIdx;
            w_nextErr  = 1'b0;
            w_nextLast = (w_muxIdx == LAST_IDX);
          end
        end
      end
      default: begin
        w_nextState = RB_IDLE;
      end
    endcase
  end

  // State register; clear aborts any transfer immediately
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= RB_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Beat snapshot registers, zeroed by clear so no partial transfer survives
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_burst <= 1'b0;
    end else begin
      r_data  <= w_nextData;
      r_idx   <= w_nextIdx;
      r_last  <= w_nextLast;
      r_err   <= w_nextErr;
      r_burst <= w_nextBurst;
    end
  end

  assign rd_data  = r_data;
  assign rd_idx   = r_idx;
  assign rd_last  = r_last;
  assign rd_err   = r_err;
  assign rd_valid = (r_state == RB_VALID);
  assign busy     = (r_state != RB_IDLE);

endmodule

// File: tb/tb_reg_bank_reader.sv
// Bench for reg_bank_reader: a scoreboard of expected beats fed at request
// time and drained by a monitor on every accepted beat, plus a 3-register
// instance for the out-of-range path.
module tb_reg_bank_reader;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
    logic       err;
  } beat_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [7:0]  regs [4];
  logic [31:0] regBus;
  logic [23:0] regBus3;

  logic       rd_req, rd_burst, rd_ack;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic [1:0] rd_idx;
  logic       rd_valid, rd_last, rd_err, busy;

  logic       req3, burst3, ack3;
  logic [1:0] sel3;
  logic [7:0] data3;
  logic [1:0] idx3;
  logic       valid3, last3, err3, busy3;

  int    checks = 0;
  int    errors = 0;
  beat_t expQ[$];
  beat_t monExp;

  assign regBus  = {regs[3], regs[2], regs[1], regs[0]};
  assign regBus3 = {regs[2], regs[1], regs[0]};

  always #5 clk = ~clk;

  reg_bank_reader #(.n(8), .NREGS(4), .SEL_W(2)) dut (
    .clk(clk), .clear(clear), .reg_bus(regBus),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_burst(rd_burst), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_err(rd_err), .busy(busy)
  );

  reg_bank_reader #(.n(8), .NREGS(3), .SEL_W(2)) dut3 (
    .clk(clk), .clear(clear), .reg_bus(regBus3),
    .rd_req(req3), .rd_sel(sel3), .rd_burst(burst3), .rd_ack(ack3),
    .rd_data(data3), .rd_idx(idx3), .rd_valid(valid3),
    .rd_last(last3), .rd_err(err3), .busy(busy3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a request is the list of registers it names, each read as-is
  task automatic pushModel(input int sel, input bit burst, input int nregs);
    beat_t b;
    int    stop;
    if (sel >= nregs) begin
      b.data = 8'h00; b.idx = 2'(sel); b.last = 1'b1; b.err = 1'b1;
      expQ.push_back(b);
    end else begin
      stop = burst ? nregs : sel + 1;
      for (int k = sel; k < stop; k++) begin
        b.data = regs[k];
        b.idx  = 2'(k);
        b.last = (k == stop - 1);
        b.err  = 1'b0;
        expQ.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input int sel, input bit burst);
    pushModel(sel, burst, 4);
    rd_req   = 1'b1;
    rd_sel   = 2'(sel);
    rd_burst = burst;
    tick;
    rd_req = 1'b0;
    checkOutput("latencyValid", rd_valid, 1);
    checkOutput("latencyBusy", busy, 1);
  endtask

  task automatic waitDone(input int ackPct, input bit noise);
    int n;
    n = 0;
    while (rd_valid && n < 60) begin
      rd_ack = ($urandom_range(0, 99) < ackPct);
      if (noise) begin
        rd_req   = ($urandom_range(0, 3) == 0);
        rd_sel   = 2'($urandom_range(0, 3));
        rd_burst = 1'($urandom_range(0, 1));
      end
      tick;
      rd_req = 1'b0;
      n++;
    end
    rd_ack = 1'b0;
    checkOutput("doneWithinBudget", rd_valid, 0);
    checkOutput("busyAfterDone", busy, 0);
    checkOutput("queueDrained", expQ.size(), 0);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "Data"}, rd_data, 0);
    checkOutput({tag, "Idx"}, rd_idx, 0);
    checkOutput({tag, "Valid"}, rd_valid, 0);
    checkOutput({tag, "Last"}, rd_last, 0);
    checkOutput({tag, "Err"}, rd_err, 0);
    checkOutput({tag, "Busy"}, busy, 0);
  endtask

  // Monitor: every presented beat must match the scoreboard head; an ack retires it
  always @(negedge clk) begin
    if (!clear && rd_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedBeat: got idx %0d data %0h, expected no beat", rd_idx, rd_data);
      end else begin
        monExp = expQ[0];
        checkOutput("beatData", rd_data, monExp.data);
        checkOutput("beatIdx", rd_idx, monExp.idx);
        checkOutput("beatLast", rd_last, monExp.last);
        checkOutput("beatErr", rd_err, monExp.err);
        if (rd_ack) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    regs[0] = 8'h01; regs[1] = 8'h03; regs[2] = 8'h07; regs[3] = 8'h0F;
    rd_req = 0; rd_sel = 0; rd_burst = 0; rd_ack = 0;
    req3 = 0; sel3 = 0; burst3 = 0; ack3 = 0;
    clear = 1'b1;
    #2;
    checkZero("resetInit");
    #10 clear = 1'b0;
    tick;

    // Asynchronous clear in the middle of a held beat
    applyStimulus(2, 0);
    #2 clear = 1'b1;
    expQ.delete();
    #1 checkZero("asyncClear");
    #2 clear = 1'b0;
    tick;

    // Single read of reg 2, ack after three cycles of valid
    applyStimulus(2, 0);
    tick;
    tick;
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    checkOutput("singleValidDrop", rd_valid, 0);
    checkOutput("singleBusyDrop", busy, 0);
    checkOutput("singleQueue", expQ.size(), 0);

    // Burst from reg 1 with ack held: three back-to-back beats
    applyStimulus(1, 1);
    rd_ack = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10 && rd_valid; i++) begin
      tick;
      cnt++;
    end
    rd_ack = 1'b0;
    checkOutput("burstBeatCycles", cnt, 3);
    checkOutput("burstBusyAfter", busy, 0);

    // Snapshot: reg 2 changes while its beat is held unacked
    applyStimulus(2, 0);
    regs[2] = 8'hFF;
    tick;
    tick;
    tick;
    checkOutput("snapshotHold", rd_data, 8'h07);
    regs[2] = 8'h07;
    waitDone(100, 0);

    // Abort a burst after its first beat, then a fresh single read
    applyStimulus(0, 1);
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    checkOutput("abortSecondBeat", rd_idx, 1);
    #2 clear = 1'b1;
    expQ.delete();
    #1 checkZero("abort");
    #2 clear = 1'b0;
    tick;
    applyStimulus(3, 0);
    checkOutput("freshReadData", rd_data, 8'h0F);
    waitDone(100, 0);

    // Randomised traffic with random acks and requests thrown in while busy
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) regs[k] = 8'($urandom_range(0, 255));
      applyStimulus(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      waitDone(int'($urandom_range(30, 100)), 1);
      if ($urandom_range(0, 1) == 1) tick;
    end

    // Three-register bank: out-of-range start and a burst ending at reg 2
    regs[0] = 8'h01; regs[1] = 8'h03; regs[2] = 8'h07; regs[3] = 8'h0F;
    req3 = 1'b1; sel3 = 2'd3; burst3 = 1'b0;
    tick;
    req3 = 1'b0;
    checkOutput("rangeValid", valid3, 1);
    checkOutput("rangeData", data3, 0);
    checkOutput("rangeErr", err3, 1);
    checkOutput("rangeLast", last3, 1);
    checkOutput("rangeIdx", idx3, 3);
    req3 = 1'b1; sel3 = 2'd0;
    tick;
    req3 = 1'b0;
    checkOutput("busyReqIgnoredIdx", idx3, 3);
    checkOutput("busyReqIgnoredErr", err3, 1);
    ack3 = 1'b1;
    tick;
    ack3 = 1'b0;
    checkOutput("rangeDoneValid", valid3, 0);
    checkOutput("rangeDoneBusy", busy3, 0);
    tick;
    checkOutput("noQueuedReq", valid3, 0);
    req3 = 1'b1; sel3 = 2'd1; burst3 = 1'b1;
    tick;
    req3 = 1'b0;
    checkOutput("burst3FirstData", data3, 8'h03);
    checkOutput("burst3FirstLast", last3, 0);
    ack3 = 1'b1;
    tick;
    checkOutput("burst3SecondData", data3, 8'h07);
    checkOutput("burst3SecondIdx", idx3, 2);
    checkOutput("burst3SecondLast", last3, 1);
    checkOutput("burst3SecondErr", err3, 0);
    tick;
    ack3 = 1'b0;
    checkOutput("burst3Done", valid3, 0);

    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
